// File: rtl/bcd_scan_display_pkg.sv
// rtl/bcd_scan_display_pkg.sv - shared BCD widths and seven-segment patterns
package bcd_scan_display_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment patterns, bit order g..a (seg[0]=a)
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_seg_decoder.sv
// rtl/bcd_seg_decoder.sv - combinational BCD digit to seven-segment decoder
module bcd_seg_decoder
    import bcd_scan_display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    // Codes above 9 cannot occur in a well-formed count; blank them anyway
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - cascaded BCD counter with latched multiplexed 7-seg display
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        cin,
    input  logic                        clr,
    input  logic                        latch,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic                        ovf,
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       an
);

    localparam int CNT_W = BCD_W * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      disp_q, disp_d;
    logic [PRE_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic [BCD_W-1:0]      sel_digit;
    logic [6:0]            sel_seg;
    logic                  carry;

    // Ripple the increment through the decades; a carry out of the top digit is overflow
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        carry   = cin;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (count_q[i*BCD_W +: BCD_W] == BCD_MAX) begin
                    count_d[i*BCD_W +: BCD_W] = '0;
                end else begin
                    count_d[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + 1'b1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            ovf_d = 1'b1;
        end
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // Display register captures the pre-edge count; clr never touches it
    always_comb begin
        disp_d = disp_q;
        if (latch) begin
            disp_d = count_q;
        end
    end

    // Free-running prescaler steps the scan index once every SCAN_DIV cycles
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Pick the display digit under the current scan index
    always_comb begin
        sel_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_digit = disp_q[i*BCD_W +: BCD_W];
            end
        end
    end

    bcd_seg_decoder u_seg_decoder (
        .bcd (sel_digit),
        .seg (sel_seg)
    );

    // an and seg are both derived from the same index so they stay in step
    always_comb begin
        an_d  = NUM_DIGITS'(1) << idx_q;
        seg_d = sel_seg;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            disp_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= NUM_DIGITS'(1);
            seg_q   <= SEG_0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            disp_q  <= disp_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign digits = count_q;
    assign ovf    = ovf_q;
    assign an     = an_q;
    assign seg    = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - randomized self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

    localparam int N  = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cin;
    logic          clr;
    logic          latch;
    logic [4*N-1:0] digits;
    logic          ovf;
    logic [6:0]    seg;
    logic [N-1:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integers
    int m_cnt;
    int m_disp;
    bit m_ovf;
    int m_k;

    logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_scan_display #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .cin    (cin),
        .clr    (clr),
        .latch  (latch),
        .digits (digits),
        .ovf    (ovf),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    function automatic int p10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'((v / p10(i)) % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_disp = 0;
        m_ovf  = 1'b0;
        m_k    = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it
    task automatic tick(input logic c, input logic cl, input logic la);
        int          idx;
        logic [31:0] exp_seg;
        logic [31:0] exp_an;
        cin   = c;
        clr   = cl;
        latch = la;
        @(posedge clk);
        m_k++;
        idx     = ((m_k - 1) / SD) % N;
        exp_an  = 32'(1) << idx;
        exp_seg = 32'(pat[(m_disp / p10(idx)) % 10]);
        if (la) m_disp = m_cnt;
        if (cl) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (c) begin
            m_cnt++;
            if (m_cnt == p10(N)) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end
        end
        #1;
        check("digits", 32'(digits), to_bcd(m_cnt));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("an", 32'(an), exp_an);
        check("seg", 32'(seg), exp_seg);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_ovf"}, 32'(ovf), 32'h0);
        check({tag, "_an"}, 32'(an), 32'h1);
        check({tag, "_seg"}, 32'(seg), 32'h3F);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        cin = 1'b0; clr = 1'b0; latch = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rstn = 1'b0;
        cin = 1'b0; clr = 1'b0; latch = 1'b0;
        model_reset();
        do_reset();

        // Single pulses separated by idle cycles
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        check("nine_pulses", 32'(digits), 32'h0009);
        tick(1'b1, 1'b0, 1'b0);
        check("ten_pulses", 32'(digits), 32'h0010);
        check("ten_ovf", 32'(ovf), 32'h0);

        // Full-scale wrap and sticky overflow
        tick(1'b0, 1'b1, 1'b0);
        pulses(9999);
        check("preload_9999", 32'(digits), 32'h9999);
        tick(1'b1, 1'b0, 1'b0);
        check("wrap_digits", 32'(digits), 32'h0000);
        check("wrap_ovf", 32'(ovf), 32'h1);
        pulses(5);
        check("post_wrap_digits", 32'(digits), 32'h0005);
        check("post_wrap_ovf", 32'(ovf), 32'h1);

        // clr beats a simultaneous cin
        tick(1'b0, 1'b1, 1'b0);
        pulses(42);
        check("at_42", 32'(digits), 32'h0042);
        tick(1'b1, 1'b1, 1'b0);
        check("clr_cin_digits", 32'(digits), 32'h0000);
        check("clr_cin_ovf", 32'(ovf), 32'h0);

        // Latch with simultaneous cin, then watch the scan
        pulses(1234);
        tick(1'b1, 1'b0, 1'b1);
        check("latch_cin_digits", 32'(digits), 32'h1235);
        for (int i = 0; i < 4 * SD * N; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            case (an)
                4'b0001: check("scan_d0", 32'(seg), 32'h66);
                4'b0010: check("scan_d1", 32'(seg), 32'h4F);
                4'b0100: check("scan_d2", 32'(seg), 32'h5B);
                4'b1000: check("scan_d3", 32'(seg), 32'h06);
                default: check("scan_onehot", 32'(an), 32'h1);
            endcase
        end

        // Asynchronous reset mid-scan
        tick(1'b0, 1'b1, 1'b0);
        pulses(571);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("at_571", 32'(digits), 32'h0571);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Continuous carry stream straight out of reset
        pulses(25);
        check("stream_25", 32'(digits), 32'h0025);

        // Randomized mix against the model
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
